// File: rtl/scsi_io_arb_if.sv
// rtl/scsi_io_arb_if.sv - target-side and host-side signal bundle for scsi_io_arb
interface scsi_io_arb_if #(
    parameter int NUM_TGT = 2,
    parameter int LBA_W   = 32
);
    logic [NUM_TGT-1:0]       tgt_rd;
    logic [NUM_TGT-1:0]       tgt_wr;
    logic [NUM_TGT*LBA_W-1:0] tgt_lba;
    logic [NUM_TGT-1:0]       tgt_ack;
    logic [NUM_TGT*8-1:0]     tgt_buff_din;
    logic [8:0]               tgt_buff_addr;
    logic [7:0]               tgt_buff_dout;
    logic [NUM_TGT-1:0]       tgt_buff_wr;
    logic [LBA_W-1:0]         sd_lba;
    logic                     sd_rd;
    logic                     sd_wr;
    logic [2:0]               sd_dev;
    logic                     sd_ack;
    logic [8:0]               sd_buff_addr;
    logic [7:0]               sd_buff_dout;
    logic                     sd_buff_wr;
    logic [7:0]               sd_buff_din;
    logic                     busy;

    modport master (
        input  tgt_rd, tgt_wr, tgt_lba, tgt_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output tgt_ack, tgt_buff_addr, tgt_buff_dout, tgt_buff_wr,
        output sd_lba, sd_rd, sd_wr, sd_dev, sd_buff_din, busy
    );

    modport slave (
        output tgt_rd, tgt_wr, tgt_lba, tgt_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  tgt_ack, tgt_buff_addr, tgt_buff_dout, tgt_buff_wr,
        input  sd_lba, sd_rd, sd_wr, sd_dev, sd_buff_din, busy
    );
endinterface

// File: rtl/scsi_io_arb.sv
// rtl/scsi_io_arb.sv - round-robin sector arbiter from SCSI targets to one host I/O channel
// Optional host-response watchdog (err port, TIMEOUT parameter) under `SCSI_IO_TIMEOUT_EN.
module scsi_io_arb #(
    parameter int NUM_TGT = 2,
    parameter int LBA_W   = 32
`ifdef SCSI_IO_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scsi_io_arb_if.master        arb_bus
`ifdef SCSI_IO_TIMEOUT_EN
    ,
    output logic                 err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE,
        S_TMO
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_ptr, w_ptr_nxt;
    logic [2:0]         r_grant, w_grant_nxt;
    logic               r_sd_rd, w_sd_rd_nxt;
    logic               r_sd_wr, w_sd_wr_nxt;
    logic [LBA_W-1:0]   r_sd_lba, w_sd_lba_nxt;

    logic [7:0]         w_pend8;
    logic [7:0]         w_rd8;
    logic               w_found;
    logic [2:0]         w_win;
    logic [3:0]         w_sum;
    logic [LBA_W-1:0]   w_win_lba;
    logic [NUM_TGT-1:0] w_grant_oh;
    logic [7:0]         w_din_sel;

`ifdef SCSI_IO_TIMEOUT_EN
    logic [23:0]        r_tmo_cnt, w_tmo_cnt_nxt;
    logic               r_err, w_err_nxt;
`endif

    assign w_pend8 = 8'(arb_bus.tgt_rd | arb_bus.tgt_wr);
    assign w_rd8   = 8'(arb_bus.tgt_rd);

    // First pending target at or after the pointer, wrapping modulo NUM_TGT.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            w_sum = {1'b0, r_ptr} + 4'(i);
            if (w_sum >= 4'(NUM_TGT)) begin
                w_sum = w_sum - 4'(NUM_TGT);
            end
            if (!w_found && w_pend8[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[2:0];
            end
        end
    end

    always_comb begin
        w_win_lba  = '0;
        w_din_sel  = '0;
        w_grant_oh = '0;
        for (int g = 0; g < NUM_TGT; g++) begin
            if (3'(g) == w_win) begin
                w_win_lba = arb_bus.tgt_lba[g*LBA_W +: LBA_W];
            end
            if (3'(g) == r_grant) begin
                w_din_sel     = arb_bus.tgt_buff_din[g*8 +: 8];
                w_grant_oh[g] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_sd_rd   <= 1'b0;
            r_sd_wr   <= 1'b0;
            r_sd_lba  <= '0;
`ifdef SCSI_IO_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_sd_rd   <= w_sd_rd_nxt;
            r_sd_wr   <= w_sd_wr_nxt;
            r_sd_lba  <= w_sd_lba_nxt;
`ifdef SCSI_IO_TIMEOUT_EN
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_err     <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_sd_rd_nxt   = r_sd_rd;
        w_sd_wr_nxt   = r_sd_wr;
        w_sd_lba_nxt  = r_sd_lba;
`ifdef SCSI_IO_TIMEOUT_EN
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_err_nxt     = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                // A host still finishing a previous sector must drop sd_ack first.
                if (w_found && !arb_bus.sd_ack) begin
                    w_grant_nxt  = w_win;
                    w_sd_lba_nxt = w_win_lba;
                    w_sd_rd_nxt  = w_rd8[w_win];
                    w_sd_wr_nxt  = !w_rd8[w_win];
                    w_state_nxt  = S_REQ;
`ifdef SCSI_IO_TIMEOUT_EN
                    w_tmo_cnt_nxt = '0;
`endif
                end
            end
            S_REQ: begin
                if (arb_bus.sd_ack) begin
                    w_sd_rd_nxt = 1'b0;
                    w_sd_wr_nxt = 1'b0;
                    w_state_nxt = S_XFER;
                end
`ifdef SCSI_IO_TIMEOUT_EN
                else if (r_tmo_cnt == 24'(TIMEOUT - 24'd1)) begin
                    w_sd_rd_nxt   = 1'b0;
                    w_sd_wr_nxt   = 1'b0;
                    w_tmo_cnt_nxt = '0;
                    w_err_nxt     = 1'b1;
                    w_state_nxt   = S_TMO;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 24'd1;
                end
`endif
            end
            S_XFER: begin
                if (!arb_bus.sd_ack) begin
                    w_state_nxt = S_DONE;
                end
            end
`ifdef SCSI_IO_TIMEOUT_EN
            S_TMO: begin
                if (r_tmo_cnt == 24'd1) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 24'd1;
                end
            end
`endif
            S_DONE: begin
                w_ptr_nxt   = (r_grant == 3'(NUM_TGT - 1)) ? 3'd0 : r_grant + 3'd1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        arb_bus.tgt_ack     = '0;
        arb_bus.tgt_buff_wr = '0;
        if (r_state == S_XFER) begin
            arb_bus.tgt_ack     = arb_bus.sd_ack ? w_grant_oh : '0;
            arb_bus.tgt_buff_wr = arb_bus.sd_buff_wr ? w_grant_oh : '0;
        end
`ifdef SCSI_IO_TIMEOUT_EN
        // Fake ack pulse lets the abandoned target see a complete io_ack cycle.
        if (r_state == S_TMO) begin
            arb_bus.tgt_ack = w_grant_oh;
        end
`endif
    end

    assign arb_bus.sd_buff_din   = (r_state != S_IDLE) ? w_din_sel : 8'd0;
    assign arb_bus.tgt_buff_addr = arb_bus.sd_buff_addr;
    assign arb_bus.tgt_buff_dout = arb_bus.sd_buff_dout;
    assign arb_bus.sd_lba        = r_sd_lba;
    assign arb_bus.sd_rd         = r_sd_rd;
    assign arb_bus.sd_wr         = r_sd_wr;
    assign arb_bus.sd_dev        = r_grant;
    assign arb_bus.busy          = (r_state != S_IDLE);

`ifdef SCSI_IO_TIMEOUT_EN
    assign err = r_err;
`endif

endmodule

// File: tb/tb_scsi_io_arb.sv
// tb/tb_scsi_io_arb.sv - scoreboard bench for scsi_io_arb
module tb_scsi_io_arb;
    localparam int NT = 2;
    localparam int LW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scsi_io_arb_if #(.NUM_TGT(NT), .LBA_W(LW)) bus ();

`ifdef SCSI_IO_TIMEOUT_EN
    logic err;
    scsi_io_arb #(.NUM_TGT(NT), .LBA_W(LW), .TIMEOUT(24'd16)) dut (
        .clk(clk), .rst_n(rst_n), .arb_bus(bus), .err(err));
`else
    scsi_io_arb #(.NUM_TGT(NT), .LBA_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .arb_bus(bus));
`endif

    typedef struct {
        logic [2:0]  dev;
        logic        rd;
        logic        wr;
        logic [31:0] lba;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [7:0] din_of(input int g, input logic [8:0] a);
        return a[7:0] ^ ((g == 0) ? 8'hA5 : 8'h3C) ^ {7'd0, a[8]};
    endfunction

    assign bus.tgt_buff_din = {din_of(1, bus.tgt_buff_addr), din_of(0, bus.tgt_buff_addr)};

    task automatic push_exp(input logic [2:0] dev, input logic rd, input logic wr, input logic [31:0] lba);
        exp_t e;
        e.dev = dev; e.rd = rd; e.wr = wr; e.lba = lba;
        exp_q.push_back(e);
    endtask

    task automatic host_serve(input int nbytes, input bit host_wr,
                              input logic [NT-1:0] clr_rd, input logic [NT-1:0] clr_wr);
        int waited = 0;
        exp_t e;
        logic [NT-1:0] oh;
        while (!(bus.sd_rd || bus.sd_wr) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!(bus.sd_rd || bus.sd_wr)) begin
            n_fail++;
            $display("FAIL grant_wait: no sd_rd/sd_wr after %0d cycles", waited);
            return;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL grant_unexpected: dev=%0d rd=%b wr=%b with empty scoreboard", bus.sd_dev, bus.sd_rd, bus.sd_wr);
            return;
        end
        e = exp_q.pop_front();
        oh = NT'(1) << e.dev;
        n_checks++;
        if ({bus.sd_dev, bus.sd_rd, bus.sd_wr} !== {e.dev, e.rd, e.wr})
            begin n_fail++; $display("FAIL grant: got dev=%0d rd=%b wr=%b expected dev=%0d rd=%b wr=%b", bus.sd_dev, bus.sd_rd, bus.sd_wr, e.dev, e.rd, e.wr); end
        n_checks++;
        if (bus.sd_lba !== e.lba)
            begin n_fail++; $display("FAIL sd_lba: got %h expected %h", bus.sd_lba, e.lba); end
        bus.sd_ack = 1'b1;
        bus.tgt_rd = bus.tgt_rd & ~clr_rd;
        bus.tgt_wr = bus.tgt_wr & ~clr_wr;
        @(negedge clk);
        n_checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.tgt_ack} !== {2'b00, oh})
            begin n_fail++; $display("FAIL xfer_entry: got rd/wr=%b%b tgt_ack=%b expected 00 %b", bus.sd_rd, bus.sd_wr, bus.tgt_ack, oh); end
        for (int a = 0; a < nbytes; a++) begin
            bus.sd_buff_addr = 9'(a);
            bus.sd_buff_dout = 8'(a * 3);
            bus.sd_buff_wr   = host_wr;
            #1;
            n_checks++;
            if (bus.tgt_buff_wr !== (host_wr ? oh : NT'(0)))
                begin n_fail++; $display("FAIL buff_wr: addr %0d got %b expected %b", a, bus.tgt_buff_wr, host_wr ? oh : NT'(0)); end
            n_checks++;
            if ({bus.tgt_buff_addr, bus.tgt_buff_dout} !== {9'(a), 8'(a * 3)})
                begin n_fail++; $display("FAIL buff_bcast: got %h/%h expected %h/%h", bus.tgt_buff_addr, bus.tgt_buff_dout, 9'(a), 8'(a * 3)); end
            n_checks++;
            if (bus.sd_buff_din !== din_of(int'(e.dev), 9'(a)))
                begin n_fail++; $display("FAIL sd_buff_din: addr %0d got %h expected %h", a, bus.sd_buff_din, din_of(int'(e.dev), 9'(a))); end
            @(negedge clk);
        end
        bus.sd_ack     = 1'b0;
        bus.sd_buff_wr = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.tgt_ack, bus.tgt_buff_wr, bus.busy} !== {NT'(0), NT'(0), 1'b1})
            begin n_fail++; $display("FAIL done_state: got ack=%b bwr=%b busy=%b expected 0 0 1", bus.tgt_ack, bus.tgt_buff_wr, bus.busy); end
        bus.sd_buff_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0)
            begin n_fail++; $display("FAIL busy_release: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset();
        bus.tgt_rd = '0; bus.tgt_wr = '0; bus.tgt_lba = '0;
        bus.sd_ack = 1'b0; bus.sd_buff_addr = '0; bus.sd_buff_dout = '0; bus.sd_buff_wr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.sd_dev, bus.busy} !== 6'd0)
            begin n_fail++; $display("FAIL reset_ctrl: got rd=%b wr=%b dev=%0d busy=%b expected all 0", bus.sd_rd, bus.sd_wr, bus.sd_dev, bus.busy); end
        n_checks++;
        if ({bus.sd_lba, bus.tgt_ack, bus.tgt_buff_wr, bus.sd_buff_din} !== '0)
            begin n_fail++; $display("FAIL reset_data: got lba=%h ack=%b bwr=%b din=%h expected 0", bus.sd_lba, bus.tgt_ack, bus.tgt_buff_wr, bus.sd_buff_din); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        bus.tgt_lba[31:0] = 32'h123;
        bus.tgt_rd = 2'b01;
        push_exp(3'd0, 1'b1, 1'b0, 32'h123);
        n_checks++;
        if (bus.sd_rd !== 1'b0)
            begin n_fail++; $display("FAIL rd_latency_early: got %b expected 0", bus.sd_rd); end
        @(negedge clk);
        n_checks++;
        if ({bus.sd_rd, bus.busy} !== 2'b11)
            begin n_fail++; $display("FAIL rd_latency: got rd=%b busy=%b expected 1 1", bus.sd_rd, bus.busy); end
        host_serve(512, 1'b1, 2'b01, 2'b00);
    endtask

    task automatic test_write();
        bus.tgt_lba[63:32] = 32'd7;
        bus.tgt_wr = 2'b10;
        push_exp(3'd1, 1'b0, 1'b1, 32'd7);
        @(negedge clk);
        n_checks++;
        if (bus.sd_wr !== 1'b1)
            begin n_fail++; $display("FAIL wr_latency: got %b expected 1", bus.sd_wr); end
        host_serve(512, 1'b0, 2'b00, 2'b10);
    endtask

    task automatic test_fairness();
        bus.tgt_lba = {32'h200, 32'h100};
        bus.tgt_rd = 2'b11;
        push_exp(3'd0, 1'b1, 1'b0, 32'h100);
        push_exp(3'd1, 1'b1, 1'b0, 32'h200);
        push_exp(3'd0, 1'b1, 1'b0, 32'h100);
        push_exp(3'd1, 1'b1, 1'b0, 32'h200);
        for (int s = 0; s < 4; s++)
            host_serve(4, 1'b0, (s == 3) ? 2'b11 : 2'b00, 2'b00);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.sd_rd, bus.busy} !== 2'b00)
            begin n_fail++; $display("FAIL fair_idle: got rd=%b busy=%b expected 0 0", bus.sd_rd, bus.busy); end
    endtask

    task automatic test_rw_tie();
        bus.tgt_lba[31:0] = 32'h55;
        bus.tgt_rd = 2'b01;
        bus.tgt_wr = 2'b01;
        push_exp(3'd0, 1'b1, 1'b0, 32'h55);
        push_exp(3'd0, 1'b0, 1'b1, 32'h55);
        host_serve(4, 1'b1, 2'b01, 2'b00);
        host_serve(4, 1'b0, 2'b00, 2'b01);
    endtask

    task automatic test_async_reset();
        bus.tgt_lba = {32'h77, 32'h66};
        bus.tgt_rd = 2'b10;
        @(negedge clk);
        n_checks++;
        if ({bus.sd_rd, bus.sd_dev} !== {1'b1, 3'd1})
            begin n_fail++; $display("FAIL ar_grant: got rd=%b dev=%0d expected 1 1", bus.sd_rd, bus.sd_dev); end
        bus.sd_ack = 1'b1;
        bus.tgt_rd = 2'b00;
        @(negedge clk);
        n_checks++;
        if (bus.tgt_ack !== 2'b10)
            begin n_fail++; $display("FAIL ar_xfer_ack: got %b expected 10", bus.tgt_ack); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.tgt_ack, bus.busy} !== 5'd0)
            begin n_fail++; $display("FAIL ar_async: got rd=%b wr=%b ack=%b busy=%b expected all 0", bus.sd_rd, bus.sd_wr, bus.tgt_ack, bus.busy); end
        bus.sd_ack = 1'b0;
        bus.tgt_rd = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(3'd0, 1'b1, 1'b0, 32'h66);
        push_exp(3'd1, 1'b1, 1'b0, 32'h77);
        host_serve(4, 1'b0, 2'b01, 2'b00);
        host_serve(4, 1'b0, 2'b10, 2'b00);
    endtask

    task automatic test_ack_high_idle();
        bus.sd_ack = 1'b1;
        bus.tgt_rd = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.sd_rd, bus.busy} !== 2'b00)
                begin n_fail++; $display("FAIL ack_idle_hold: cycle %0d got rd=%b busy=%b expected 0 0", c, bus.sd_rd, bus.busy); end
        end
        bus.sd_ack = 1'b0;
        push_exp(3'd0, 1'b1, 1'b0, 32'h66);
        host_serve(2, 1'b0, 2'b01, 2'b00);
    endtask

`ifdef SCSI_IO_TIMEOUT_EN
    task automatic test_timeout();
        bus.tgt_lba[31:0] = 32'h9;
        bus.tgt_rd = 2'b01;
        @(negedge clk);
        bus.tgt_rd = 2'b00;
        n_checks++;
        if ({bus.sd_rd, err} !== 2'b10)
            begin n_fail++; $display("FAIL tmo_start: got rd=%b err=%b expected 1 0", bus.sd_rd, err); end
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sd_rd !== 1'b1)
                begin n_fail++; $display("FAIL tmo_hold: cycle %0d got rd=%b expected 1", c, bus.sd_rd); end
        end
        @(negedge clk);
        n_checks++;
        if ({bus.sd_rd, bus.tgt_ack, err} !== 4'b0011)
            begin n_fail++; $display("FAIL tmo_fire: got rd=%b ack=%b err=%b expected 0 01 1", bus.sd_rd, bus.tgt_ack, err); end
        @(negedge clk);
        n_checks++;
        if (bus.tgt_ack !== 2'b01)
            begin n_fail++; $display("FAIL tmo_ack2: got %b expected 01", bus.tgt_ack); end
        @(negedge clk);
        n_checks++;
        if ({bus.tgt_ack, err} !== 3'b001)
            begin n_fail++; $display("FAIL tmo_ack_end: got ack=%b err=%b expected 00 1", bus.tgt_ack, err); end
        @(negedge clk);
        n_checks++;
        if ({bus.busy, err} !== 2'b01)
            begin n_fail++; $display("FAIL tmo_sticky: got busy=%b err=%b expected 0 1", bus.busy, err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_fairness();
        test_rw_tie();
        test_async_reset();
        test_ack_high_idle();
`ifdef SCSI_IO_TIMEOUT_EN
        test_timeout();
`endif
        n_checks++;
        if (exp_q.size() != 0)
            begin n_fail++; $display("FAIL scoreboard_drain: %0d grants never seen, expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/scsi_io_arb.md
Name: scsi_io_arb

Overview:
Downstream arbiter between NUM_TGT SCSI target instances and the single sector-based host I/O channel (the SD/image interface of the IO controller). It collects each target's io_rd/io_wr/io_lba requests and serves them one sector at a time with round-robin arbitration. During the host handshake it routes the host's sd_ack and sector-buffer traffic to the granted target only. It replaces the per-target wiring to the host with one shared, sequenced channel.

Parameters:
NUM_TGT, 2, number of SCSI targets served (1..8)
LBA_W, 32, width of the LBA per target and on the host side

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
tgt_rd  in  NUM_TGT  per-target sector read request (target io_rd)
tgt_wr  in  NUM_TGT  per-target sector write request (target io_wr)
tgt_lba  in  NUM_TGT*LBA_W  per-target LBA; target g occupies slice [g*LBA_W +: LBA_W]
tgt_ack  out  NUM_TGT  per-target io_ack
tgt_buff_din  in  NUM_TGT*8  per-target sector-buffer read data (target sd_buff_din)
tgt_buff_addr  out  9  byte address broadcast to all targets
tgt_buff_dout  out  8  byte data broadcast to all targets
tgt_buff_wr  out  NUM_TGT  per-target buffer write strobe; only the granted bit can be high
sd_lba  out  LBA_W  host LBA
sd_rd  out  1  host read request
sd_wr  out  1  host write request
sd_dev  out  3  index of the granted target
sd_ack  in  1  host acknowledge; high for the whole sector transfer
sd_buff_addr  in  9  host buffer byte address
sd_buff_dout  in  8  host-to-target data
sd_buff_wr  in  1  host write strobe
sd_buff_din  out  8  target-to-host data from the granted target
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0, grant index 0.
- Reset is asynchronous. Asserting rst_n low mid-transfer drops sd_rd, sd_wr and tgt_ack immediately. Requests still pending at release are re-arbitrated from pointer 0.
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE:
  - Pending set P = tgt_rd | tgt_wr. Grant only when P != 0 and sd_ack == 0.
  - If sd_ack is already high in IDLE, stay in IDLE and do not grant.
  - Winner is the first set bit of P at or after the pointer, wrapping modulo NUM_TGT.
  - On the grant edge: latch the grant index into sd_dev and latch sd_lba from that target's tgt_lba slice.
  - Set sd_rd if the winner's tgt_rd is high; otherwise set sd_wr. Read wins when both are high; the write is served on a later grant.
  - Go to REQ. sd_rd/sd_wr are therefore visible 1 cycle after the request is sampled.
- REQ: hold sd_rd/sd_wr and sd_lba stable until sd_ack == 1, even if the target withdraws its request. Then clear sd_rd and sd_wr and go to XFER.
- XFER:
  - Routing: tgt_ack[grant] = sd_ack; tgt_buff_wr[grant] = sd_buff_wr; sd_buff_din = granted target's tgt_buff_din slice.
  - tgt_buff_addr/tgt_buff_dout always follow sd_buff_addr/sd_buff_dout combinationally.
  - When sd_ack falls (sampled 0), go to DONE.
- DONE:
  - Lasts exactly 1 cycle. Set pointer = grant+1 (wrapping NUM_TGT-1 -> 0) and go to IDLE.
  - Purpose: the target sees the io_ack falling edge and advances its LBA/buffer half before it can be re-granted.
- Outside XFER, all tgt_ack bits and all tgt_buff_wr bits are 0. sd_buff_din is 0 in IDLE.
- Each grant is one sector. Back-to-back requests from the same target are interleaved fairly with the other targets.

Optional Feature:
Macro SCSI_IO_TIMEOUT_EN adds a host-response watchdog.
- With the macro defined:
  - Adds parameter TIMEOUT (default 24'd10_000_000 cycles) and output port err (1 bit, reset 0).
  - If REQ lasts TIMEOUT cycles without sd_ack, drop sd_rd/sd_wr and pulse tgt_ack[grant] high for 2 cycles so the target does not hang.
  - Set err (sticky until reset), then go to DONE.
  - The counter clears on every entry to REQ.
- Without the macro: no err port, no counter; REQ waits indefinitely.

Test Plan:
1. Single read: tgt_rd=2'b01, tgt_lba[31:0]=0x123 -> sd_rd=1, sd_dev=0, sd_lba=0x123 one cycle later. Host raises sd_ack, writes 512 bytes -> only tgt_buff_wr[0] pulses. sd_ack falls -> tgt_ack[0] falls, busy low 2 cycles later.
2. Write path: tgt_wr[1]=1, tgt_lba[63:32]=7 -> sd_wr=1, sd_dev=1, sd_lba=7. Host reads addr 0..511 -> sd_buff_din equals tgt_buff_din[15:8] each cycle.
3. Fairness: both targets hold tgt_rd continuously for 4 sectors -> sd_dev grant sequence 0,1,0,1.
4. Read/write tie: tgt_rd[0]=tgt_wr[0]=1 -> first grant sd_rd; after DONE, if tgt_wr[0] is still high -> sd_wr.
5. Async reset: rst_n low during XFER of target 1 -> sd_rd, sd_wr, tgt_ack, busy all 0 without waiting for a clock edge. After release with tgt_rd=2'b11 -> first grant sd_dev=0.
6. SCSI_IO_TIMEOUT_EN with TIMEOUT=16: sd_ack never asserted -> after 16 cycles sd_rd=0, tgt_ack[grant] high for 2 cycles, err=1 and held.
